vector_scheduler: RTL and testbench

VECTOR_SCHEDULER -- requirements
Module: vector_scheduler

---
 rtl/vector_scheduler.sv | 131 +++++++++++++
 tb/tb_vector_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_scheduler.sv
// Vector display-list scheduler: walks a display list, issues beam segments
// to a line drawer with valid/ready handshake, and waits a settle time after each.
`default_nettype none

module vector_scheduler #(
  parameter int OUT_WIDTH     = 8,
  parameter int ADDR_WIDTH    = 6,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [ADDR_WIDTH-1:0]  list_len,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic [2*OUT_WIDTH:0]   rd_data,
  output logic                   seg_valid,
  input  logic                   seg_ready,
  output logic [OUT_WIDTH-1:0]   seg_x0,
  output logic [OUT_WIDTH-1:0]   seg_y0,
  output logic [OUT_WIDTH-1:0]   seg_x1,
  output logic [OUT_WIDTH-1:0]   seg_y1,
  output logic                   seg_blank,
  output logic                   frame_done,
  output logic                   busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    ISSUE  = 3'd3,
    SETTLE = 3'd4
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   len_q;
  logic [ADDR_WIDTH-1:0]   index, index_next;
  logic [7:0]              settle_cnt;
  logic [OUT_WIDTH-1:0]    beam_x, beam_y;
  logic                    xfer, last, latch_len, frame_end;

  assign xfer = seg_valid && seg_ready;
  assign last = (index == len_q - ADDR_WIDTH'(1));
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    index_next = index;
    latch_len  = 1'b0;
    frame_end  = 1'b0;
    case (state)
      IDLE: begin
        if (enable && list_len != '0) begin
          state_next = FETCH;
          index_next = '0;
          latch_len  = 1'b1;
        end
      end
      FETCH: state_next = WAIT;
      WAIT:  state_next = ISSUE;
      ISSUE: if (xfer) state_next = SETTLE;
      SETTLE: begin
        if (settle_cnt == 8'd0) begin
          if (last) begin
            // A zero length at the frame boundary cannot start a frame.
            frame_end  = 1'b1;
            index_next = '0;
            if (enable && list_len != '0) begin
              state_next = FETCH;
              latch_len  = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            index_next = index + ADDR_WIDTH'(1);
            state_next = FETCH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q      <= '0;
      index      <= '0;
      rd_addr    <= '0;
      settle_cnt <= 8'd0;
      beam_x     <= '0;
      beam_y     <= '0;
      seg_valid  <= 1'b0;
      seg_x0     <= '0;
      seg_y0     <= '0;
      seg_x1     <= '0;
      seg_y1     <= '0;
      seg_blank  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      index      <= index_next;
      frame_done <= frame_end;
      if (latch_len)            len_q   <= list_len;
      if (state_next == FETCH)  rd_addr <= index_next;
      // rd_data is valid during WAIT; outputs are frozen from here until transfer.
      if (state == WAIT) begin
        seg_x0    <= beam_x;
        seg_y0    <= beam_y;
        seg_x1    <= rd_data[2*OUT_WIDTH-1:OUT_WIDTH];
        seg_y1    <= rd_data[OUT_WIDTH-1:0];
        seg_blank <= rd_data[2*OUT_WIDTH] | (index == '0);
        seg_valid <= 1'b1;
      end
      if (state == ISSUE && xfer) begin
        seg_valid  <= 1'b0;
        beam_x     <= seg_x1;
        beam_y     <= seg_y1;
        settle_cnt <= 8'(SETTLE_CYCLES - 1);
      end
      if (state == SETTLE && settle_cnt != 8'd0)
        settle_cnt <= settle_cnt - 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vector_scheduler.sv
// Scoreboard bench for vector_scheduler: expected segments are queued from a
// display-list model and compared on each handshake transfer.
`default_nettype none

module tb_vector_scheduler;

  localparam int OW     = 8;
  localparam int AW     = 6;
  localparam int SETTLE = 4;

  typedef struct packed {
    logic [OW-1:0] x0, y0, x1, y1;
    logic          blank;
  } seg_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [AW-1:0] list_len = '0;
  logic [AW-1:0] rd_addr;
  logic [2*OW:0] rd_data = '0;
  logic          seg_valid;
  logic          seg_ready = 1'b0;
  logic [OW-1:0] seg_x0, seg_y0, seg_x1, seg_y1;
  logic          seg_blank, frame_done, busy;

  vector_scheduler #(.OUT_WIDTH(OW), .ADDR_WIDTH(AW), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst), .enable(enable), .list_len(list_len), .rd_addr(rd_addr),
    .rd_data(rd_data), .seg_valid(seg_valid), .seg_ready(seg_ready),
    .seg_x0(seg_x0), .seg_y0(seg_y0), .seg_x1(seg_x1), .seg_y1(seg_y1),
    .seg_blank(seg_blank), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [2*OW:0] mem [0:63];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  seg_t          exp_q[$];
  logic [OW-1:0] bx = '0, by = '0;

  task automatic push_frame(input int n);
    seg_t e;
    for (int i = 0; i < n; i++) begin
      e.x0    = bx;
      e.y0    = by;
      e.x1    = mem[i][2*OW-1:OW];
      e.y1    = mem[i][OW-1:0];
      e.blank = (i == 0) ? 1'b1 : mem[i][2*OW];
      exp_q.push_back(e);
      bx = e.x1;
      by = e.y1;
    end
  endtask

  int   cyc = 0;
  int   xfer_cnt = 0, fd_cnt = 0, stall_run = 0, last_stall = 0, last_xfer_cyc = 0;
  bit   stall_on = 0, fd_prev = 0;
  seg_t prev_seg, cur, e;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    cur = '{seg_x0, seg_y0, seg_x1, seg_y1, seg_blank};
    if (rst) begin
      stall_on  = 0;
      stall_run = 0;
    end else begin
      if (stall_on) begin
        check_eq("stall_valid", 64'(seg_valid), 64'd1);
        check_eq("stall_hold", 64'(cur), 64'(prev_seg));
      end
      if (seg_valid && !seg_ready) begin
        stall_on = 1;
        prev_seg = cur;
        stall_run++;
      end else begin
        stall_on = 0;
      end
      if (seg_valid && seg_ready) begin
        xfer_cnt++;
        last_stall    = stall_run;
        stall_run     = 0;
        last_xfer_cyc = cyc;
        if (exp_q.size() == 0) begin
          check_eq("unexpected_seg", 64'(cur), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("seg", 64'(cur), 64'(e));
        end
      end
      if (frame_done) begin
        fd_cnt++;
        check_eq("fd_gap", 64'(cyc - last_xfer_cyc), 64'(SETTLE + 1));
        check_eq("fd_width", 64'(fd_prev), 64'd0);
      end
    end
    fd_prev = frame_done;
  end

  // sel: 0 = transfer count, 1 = frame_done count, other = seg_valid high
  task automatic wait_for(input string tag, input int sel, input int target);
    bit ok = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk); #1;
      case (sel)
        0:       ok = (xfer_cnt >= target);
        1:       ok = (fd_cnt >= target);
        default: ok = seg_valid;
      endcase
    end
    if (!ok) check_eq(tag, 64'd0, 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, 64'({rd_addr, seg_valid, seg_x0, seg_y0, seg_x1, seg_y1,
                       seg_blank, frame_done, busy}), 64'd0);
  endtask

  int base_x, base_f;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0] = {1'b0, 8'd10, 8'd20};
    mem[1] = {1'b0, 8'd30, 8'd40};
    mem[2] = {1'b1, 8'd50, 8'd60};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    check_eq("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // Single frame, enable dropped during segment 1
    list_len  = 6'd3;
    seg_ready = 1'b1;
    push_frame(3);
    enable = 1'b1;
    wait_for("timeout_a_seg0", 0, 1);
    enable = 1'b0;
    wait_for("timeout_a_fd", 1, 1);
    repeat (10) @(negedge clk);
    check_eq("a_xfers", 64'(xfer_cnt), 64'd3);
    check_eq("a_frames", 64'(fd_cnt), 64'd1);
    check_eq("a_idle_busy", 64'(busy), 64'd0);
    check_eq("a_rd_addr_hold", 64'(rd_addr), 64'd2);

    // Two back-to-back frames; list_len change mid-frame applies to frame 2
    base_x = xfer_cnt;
    base_f = fd_cnt;
    push_frame(3);
    push_frame(2);
    enable = 1'b1;
    wait_for("timeout_b_seg0", 0, base_x + 1);
    list_len = 6'd2;
    wait_for("timeout_b_fd1", 1, base_f + 1);
    wait_for("timeout_b_f2s0", 0, base_x + 4);
    enable = 1'b0;
    wait_for("timeout_b_fd2", 1, base_f + 2);
    repeat (10) @(negedge clk);
    check_eq("b_xfers", 64'(xfer_cnt - base_x), 64'd5);
    check_eq("b_frames", 64'(fd_cnt - base_f), 64'd2);
    check_eq("b_idle_busy", 64'(busy), 64'd0);

    // Handshake stall of 5 cycles on segment 2
    base_x    = xfer_cnt;
    base_f    = fd_cnt;
    list_len  = 6'd3;
    @(posedge clk); #1;
    seg_ready = 1'b0;
    push_frame(3);
    enable = 1'b1;
    wait_for("timeout_c_v0", 2, 0);
    @(posedge clk); #1;
    seg_ready = 1'b1;
    wait_for("timeout_c_seg0", 0, base_x + 1);
    enable = 1'b0;
    @(posedge clk); #1;
    seg_ready = 1'b0;
    wait_for("timeout_c_v1", 2, 0);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    seg_ready = 1'b1;
    wait_for("timeout_c_seg1", 0, base_x + 2);
    check_eq("c_stall_len", 64'(last_stall), 64'd5);
    wait_for("timeout_c_fd", 1, base_f + 1);
    repeat (10) @(negedge clk);
    check_eq("c_xfers", 64'(xfer_cnt - base_x), 64'd3);
    check_eq("c_frames", 64'(fd_cnt - base_f), 64'd1);

    // Zero-length list never starts
    base_f   = fd_cnt;
    list_len = '0;
    enable   = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_eq("len0_idle", 64'({busy, seg_valid, frame_done}), 64'd0);
    end
    check_eq("len0_frames", 64'(fd_cnt - base_f), 64'd0);
    enable = 1'b0;

    // Reset while a segment is offered, then beam restarts from origin
    @(posedge clk); #1;
    seg_ready = 1'b0;
    list_len  = 6'd3;
    enable    = 1'b1;
    wait_for("timeout_e_v", 2, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("e_reset_in_issue");
    enable = 1'b0;
    rst    = 1'b0;
    bx     = '0;
    by     = '0;
    base_x = xfer_cnt;
    base_f = fd_cnt;
    list_len  = 6'd1;
    seg_ready = 1'b1;
    push_frame(1);
    enable = 1'b1;
    wait_for("timeout_e_seg0", 0, base_x + 1);
    enable = 1'b0;
    wait_for("timeout_e_fd", 1, base_f + 1);
    repeat (10) @(negedge clk);
    check_eq("e_frames", 64'(fd_cnt - base_f), 64'd1);
    check_eq("e_idle_busy", 64'(busy), 64'd0);

    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
